// File: rtl/demux_1ton_hs.sv
// 1-to-N demultiplexer with a single registered holding slot and a valid/ready handshake per lane.
// Optional per-channel drain counters are compiled in when DEMUX_CNT_EN is defined.
`ifdef DEMUX_CNT_EN
module demux_cnt_lane (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [15:0] o_cnt
);
    logic [15:0] r_cnt;

    // Clear takes priority over a same-cycle drain; the count saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_cnt <= '0;
        else if (i_clr)                    r_cnt <= '0;
        else if (i_inc && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end

    assign o_cnt = r_cnt;
endmodule
`endif

module demux_1ton_hs #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [CHANNELS-1:0] out_valid,
    input  logic [CHANNELS-1:0] out_ready,
    output logic                sel_err,
`ifdef DEMUX_CNT_EN
    input  logic [SEL_W-1:0]    cnt_sel,
    input  logic                cnt_clr,
    output logic [15:0]         cnt_out,
`endif
    output logic [SEL_W-1:0]    rr_ptr
);
    localparam logic [SEL_W:0]   LP_NCH  = CHANNELS[SEL_W:0];
    localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_ch;
    logic             r_vld;
    logic             r_sel_err;
    logic [SEL_W-1:0] r_rr;

    logic             w_tgt_rdy;
    logic             w_drain;
    logic             w_acc;
    logic             w_bad;
    logic [SEL_W-1:0] w_tgt;

    // Ready of the held word's channel, picked by compare so the index width never matters.
    always_comb begin
        w_tgt_rdy = 1'b0;
        for (int i = 0; i < CHANNELS; i++)
            if (r_ch == SEL_W'(i)) w_tgt_rdy = out_ready[i];
    end

    assign w_drain  = r_vld && w_tgt_rdy;
    assign in_ready = !r_vld || w_tgt_rdy;
    assign w_acc    = in_valid && in_ready;
    assign w_bad    = !mode && ({1'b0, in_sel} >= LP_NCH);
    assign w_tgt    = mode ? r_rr : in_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_ch      <= '0;
            r_vld     <= 1'b0;
            r_sel_err <= 1'b0;
            r_rr      <= '0;
        end else begin
            r_sel_err <= w_acc && w_bad;
            if (w_acc) begin
                // A discarded word still frees the slot if the held word drains now.
                r_vld <= !w_bad;
                if (!w_bad) begin
                    r_data <= in_data;
                    r_ch   <= w_tgt;
                end
                if (mode) r_rr <= (r_rr == LP_LAST) ? '0 : r_rr + 1'b1;
            end else if (w_drain) begin
                r_vld <= 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_lane
            assign out_valid[g] = r_vld && (r_ch == SEL_W'(g));
        end
    endgenerate

    assign out_data = r_data;
    assign sel_err  = r_sel_err;
    assign rr_ptr   = r_rr;

`ifdef DEMUX_CNT_EN
    logic [15:0] w_cnt [CHANNELS];

    generate
        for (g = 0; g < CHANNELS; g++) begin : g_cnt
            demux_cnt_lane u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .i_clr (cnt_clr),
                .i_inc (w_drain && (r_ch == SEL_W'(g))),
                .o_cnt (w_cnt[g])
            );
        end
    endgenerate

    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (cnt_sel == SEL_W'(i)) cnt_out = w_cnt[i];
    end
`endif
endmodule

// File: tb/tb_demux_1ton_hs.sv
// Directed bench for demux_1ton_hs: a 4-channel instance for the main flow and a
// 3-channel instance for the out-of-range select case.
module tb_demux_1ton_hs;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode, in_valid, in_ready, sel_err;
    logic [7:0] in_data, out_data;
    logic [3:0] in_sel, rr_ptr, out_valid, out_ready;

    logic       in_valid3, in_ready3, sel_err3;
    logic [7:0] out_data3;
    logic [3:0] in_sel3, rr_ptr3;
    logic [2:0] out_valid3;

    int total = 0;
    int bad = 0;

`ifdef DEMUX_CNT_EN
    logic [3:0]  cnt_sel, cnt_sel3;
    logic        cnt_clr, cnt_clr3;
    logic [15:0] cnt_out, cnt_out3;
`endif

    always #5 clk = ~clk;

    demux_1ton_hs #(.WIDTH(8), .CHANNELS(4), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err),
`ifdef DEMUX_CNT_EN
        .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_out(cnt_out),
`endif
        .rr_ptr(rr_ptr)
    );

    demux_1ton_hs #(.WIDTH(8), .CHANNELS(3), .SEL_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(1'b0), .in_data(8'h77), .in_sel(in_sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(3'b111), .sel_err(sel_err3),
`ifdef DEMUX_CNT_EN
        .cnt_sel(cnt_sel3), .cnt_clr(cnt_clr3), .cnt_out(cnt_out3),
`endif
        .rr_ptr(rr_ptr3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_sel = 4'd0;
        out_ready = 4'b1111; in_valid3 = 1'b0; in_sel3 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rst_out_valid got=%b exp=0000", out_valid); end
            total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
            total++; if (rr_ptr !== 4'd0) begin bad++; $display("FAIL rst_rr_ptr got=%0d exp=0", rr_ptr); end
            total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL rst_sel_err got=%b exp=0", sel_err); end
        end
        rst_n = 1'b1;
        tick();
        total++; if (out_valid !== 4'b0001 || out_data !== 8'hFF) begin bad++; $display("FAIL rst_first_accept got=%b/%h exp=0001/ff", out_valid, out_data); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rst_drain got=%b exp=0000", out_valid); end
    endtask

    task automatic test_select();
        mode = 1'b0; out_ready = 4'b1111;
        in_valid = 1'b1; in_data = 8'hA1; in_sel = 4'd2;
        tick();
        total++; if (out_valid !== 4'b0100 || out_data !== 8'hA1) begin bad++; $display("FAIL sel_a1 got=%b/%h exp=0100/a1", out_valid, out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sel_rdy1 got=%b exp=1", in_ready); end
        in_data = 8'hB2; in_sel = 4'd0;
        tick();
        total++; if (out_valid !== 4'b0001 || out_data !== 8'hB2) begin bad++; $display("FAIL sel_b2 got=%b/%h exp=0001/b2", out_valid, out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sel_rdy2 got=%b exp=1", in_ready); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL sel_idle got=%b exp=0000", out_valid); end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; out_ready = 4'b1101;
        in_valid = 1'b1; in_data = 8'h55; in_sel = 4'd1;
        tick();
        in_data = 8'h66; in_sel = 4'd3;
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 4'b0010 || out_data !== 8'h55) begin bad++; $display("FAIL bp_hold c%0d got=%b/%h exp=0010/55", i, out_valid, out_data); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall c%0d got=%b exp=0", i, in_ready); end
            tick();
        end
        out_ready = 4'b1111;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
        tick();
        total++; if (out_valid !== 4'b1000 || out_data !== 8'h66) begin bad++; $display("FAIL bp_next got=%b/%h exp=1000/66", out_valid, out_data); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL bp_idle got=%b exp=0000", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_v;
        int         exp_ch [6] = '{0, 1, 2, 3, 0, 1};
        mode = 1'b1; out_ready = 4'b1111; in_sel = 4'd3; in_valid = 1'b1;
        total++; if (rr_ptr !== 4'd0) begin bad++; $display("FAIL rr_start got=%0d exp=0", rr_ptr); end
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(i + 1);
            tick();
            exp_v = 4'b0001 << exp_ch[i];
            total++; if (out_valid !== exp_v || out_data !== 8'(i + 1)) begin bad++; $display("FAIL rr_word%0d got=%b/%h exp=%b/%h", i, out_valid, out_data, exp_v, 8'(i + 1)); end
        end
        in_valid = 1'b0; mode = 1'b0;
        total++; if (rr_ptr !== 4'd2) begin bad++; $display("FAIL rr_end got=%0d exp=2", rr_ptr); end
        tick();
        total++; if (rr_ptr !== 4'd2) begin bad++; $display("FAIL rr_persist got=%0d exp=2", rr_ptr); end
    endtask

    task automatic test_bad_select();
        mode = 1'b0; out_ready = 4'b1111;
        in_valid = 1'b1; in_data = 8'h99; in_sel = 4'd5;
        in_valid3 = 1'b1; in_sel3 = 4'd3;
        tick();
        in_valid = 1'b0; in_valid3 = 1'b0;
        total++; if (out_valid !== 4'b0000 || sel_err !== 1'b1) begin bad++; $display("FAIL bad4 got=%b/%b exp=0000/1", out_valid, sel_err); end
        total++; if (rr_ptr !== 4'd2) begin bad++; $display("FAIL bad4_rr got=%0d exp=2", rr_ptr); end
        total++; if (out_valid3 !== 3'b000 || sel_err3 !== 1'b1) begin bad++; $display("FAIL bad3 got=%b/%b exp=000/1", out_valid3, sel_err3); end
        total++; if (rr_ptr3 !== 4'd0) begin bad++; $display("FAIL bad3_rr got=%0d exp=0", rr_ptr3); end
        tick();
        total++; if (sel_err !== 1'b0 || sel_err3 !== 1'b0) begin bad++; $display("FAIL bad_pulse got=%b/%b exp=0/0", sel_err, sel_err3); end
        // Bad select accepted while a held word drains in the same cycle.
        in_valid = 1'b1; in_data = 8'h3C; in_sel = 4'd0;
        tick();
        in_data = 8'hC3; in_sel = 4'd7;
        total++; if (out_valid !== 4'b0001 || out_data !== 8'h3C) begin bad++; $display("FAIL bad_pre got=%b/%h exp=0001/3c", out_valid, out_data); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 4'b0000 || sel_err !== 1'b1) begin bad++; $display("FAIL bad_drain got=%b/%b exp=0000/1", out_valid, sel_err); end
        tick();
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL bad_drain_pulse got=%b exp=0", sel_err); end
    endtask

`ifdef DEMUX_CNT_EN
    task automatic test_counters();
        mode = 1'b0; out_ready = 4'b1111; cnt_sel = 4'd2;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        total++; if (cnt_out !== 16'd0) begin bad++; $display("FAIL cnt_clr0 got=%0d exp=0", cnt_out); end
        in_valid = 1'b1; in_sel = 4'd2;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h20 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        total++; if (cnt_out !== 16'd3) begin bad++; $display("FAIL cnt_three got=%0d exp=3", cnt_out); end
        cnt_sel = 4'd5;
        #1;
        total++; if (cnt_out !== 16'd0) begin bad++; $display("FAIL cnt_oor got=%0d exp=0", cnt_out); end
        cnt_sel = 4'd2; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        total++; if (cnt_out !== 16'd0) begin bad++; $display("FAIL cnt_clr got=%0d exp=0", cnt_out); end
    endtask
`endif

    task automatic test_async_reset();
        mode = 1'b0; out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 8'h5A; in_sel = 4'd1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 4'b0010) begin bad++; $display("FAIL ar_held got=%b exp=0010", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 4'b0000 || out_data !== 8'h00 || rr_ptr !== 4'd0) begin bad++; $display("FAIL ar_clear got=%b/%h/%0d exp=0000/00/0", out_valid, out_data, rr_ptr); end
        tick();
        rst_n = 1'b1; out_ready = 4'b1111;
        tick();
    endtask

    initial begin
`ifdef DEMUX_CNT_EN
        cnt_sel = 4'd0; cnt_clr = 1'b0; cnt_sel3 = 4'd0; cnt_clr3 = 1'b0;
`endif
        test_reset();
        test_select();
        test_backpressure();
        test_round_robin();
        test_bad_select();
`ifdef DEMUX_CNT_EN
        test_counters();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux_1ton_hs.md
Name: demux_1ton_hs

Overview:
Parametrised 1-to-N demultiplexer with a registered output stage and valid/ready handshake on every lane. It generalises the team's combinational gate/demux workouts to WIDTH-bit data, N output channels and two routing modes: explicit select, or automatic round-robin. It sits between a single producer and N consumers in lab datapath exercises.

Parameters:
WIDTH, 8, data bus width in bits (>=1)
CHANNELS, 4, number of output channels (2..16)
SEL_W, 4, select width; must satisfy 2**SEL_W >= CHANNELS

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = route by in_sel, 1 = round-robin
in_data  input  WIDTH  producer data
in_sel  input  SEL_W  target channel; used only when mode=0
in_valid  input  1  producer word valid
in_ready  output  1  block can accept a word this cycle
out_data  output  WIDTH  shared registered data bus to all consumers
out_valid  output  CHANNELS  one-hot valid, bit i = channel i
out_ready  input  CHANNELS  per-channel consumer ready
sel_err  output  1  one-cycle pulse: accepted word addressed a channel >= CHANNELS
rr_ptr  output  SEL_W  current round-robin pointer (observability)

Behaviour:
- Reset (rst_n low, async): out_data=0, out_valid=0, sel_err=0, rr_ptr=0, internal hold flag vld_q=0. The block leaves reset on the next clk edge after rst_n rises.
- Internal state: data_q, ch_q, vld_q. out_data=data_q. out_valid[i] = vld_q && (ch_q==i).
- in_ready = !vld_q || out_ready[ch_q]. This is combinational and supports full throughput.
- Accept: the block accepts a word when in_valid && in_ready at a clk edge.
- Drain: the held word leaves when vld_q && out_ready[ch_q]. Drain and accept in the same cycle are legal and give back-to-back transfers.
- Latency: an accepted word appears on out_data/out_valid in the next cycle (1 cycle). The word holds stable until its channel's out_ready is high.
- Target channel: mode=0 uses in_sel; mode=1 uses rr_ptr. mode is sampled at accept time, so switching mode mid-stream affects only later words.
- Round-robin: on each accept in mode=1, rr_ptr increments and wraps from CHANNELS-1 to 0. rr_ptr is unchanged by accepts in mode=0 and persists across mode switches.
- Blocking: when the target consumer stalls, in_ready is low and input stalls. There is no bypass to other channels (in-order, single-entry).
- Out-of-range select (mode=0, in_sel >= CHANNELS): the word is accepted and discarded. vld_q is not set by it, and sel_err pulses high for exactly the next cycle.
  - If a held word drains in the same cycle, the drain proceeds normally.
- Idle: with no accept and no drain, state holds and vld_q stays at its value.
- out_ready bits of channels other than ch_q are ignored.
- Reset mid-transfer: any held word is lost and out_valid clears immediately (async).

Optional Feature:
Macro DEMUX_CNT_EN.
- Defined: adds ports cnt_sel (input, SEL_W), cnt_clr (input, 1) and cnt_out (output, 16).
  - Each channel has a 16-bit counter of words drained to it. Counters saturate at 16'hFFFF.
  - cnt_out = counter[cnt_sel] (combinational), or 0 if cnt_sel >= CHANNELS.
  - cnt_clr (synchronous) zeroes all counters. If cnt_clr and a drain occur in the same cycle, the counter ends at 0.
  - All counters reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, rr_ptr=0, sel_err=0 throughout; release -> first accept occurs on the next edge.
- Select mode, all ready: mode=0, out_ready=4'b1111, send 8'hA1 sel=2 then 8'hB2 sel=0 back-to-back -> cycle+1 out_valid=4'b0100/A1, cycle+2 out_valid=4'b0001/B2, in_ready stays 1.
- Backpressure: out_ready[1]=0, send 8'h55 sel=1 -> out_valid=4'b0010 held, in_ready=0 for 5 cycles; raise out_ready[1] -> drained next edge, in_ready=1.
- Round-robin wrap: mode=1, all ready, send 6 words 8'h01..8'h06 -> channels 0,1,2,3,0,1 in order; rr_ptr ends at 2.
- Bad select: CHANNELS=3, mode=0, send sel=3 -> no out_valid, sel_err=1 for one cycle, rr_ptr unchanged.
- DEMUX_CNT_EN: drain 3 words to channel 2, cnt_sel=2 -> cnt_out=3; assert cnt_clr -> cnt_out=0 next cycle.
